// File: rtl/device_indexer_pkg.sv
// Shared types for the device indexer: packed device names, node indices, FSM states.
// A device name is three 5-bit letters, first letter in the LSBs.
package device_indexer_pkg;
  localparam int DEVICE_BIN_BITS = 5;
  localparam int DEVICE_CHARS    = 3;
  localparam int NODE_BITS_DEF   = 10;

  typedef logic [DEVICE_BIN_BITS*DEVICE_CHARS-1:0] device_t;
  typedef logic [NODE_BITS_DEF-1:0]                node_idx_t;

  localparam device_t YOU_DEVICE = 15'h51D8;
  localparam device_t OUT_DEVICE = 15'h4E8E;

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_SRC, ST_DST, ST_EMIT} state_e;
endpackage

// File: rtl/device_indexer_name_table_ram.sv
// Single-port synchronous name table, addressed by the raw device name.
// Write-first so a block RAM primitive can be inferred.
module name_table_ram #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/device_indexer.sv
// Assigns dense node indices to device names in first-seen order and emits
// indexed edges; also tracks where "you" and "out" landed.
module device_indexer
  import device_indexer_pkg::*;
#(
  parameter int DEVICE_WIDTH = 15,
  parameter int NODE_BITS    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_done,
  input  logic                    connection_valid,
  input  logic                    connection_last,
  input  logic                    end_of_file,
  input  logic [DEVICE_WIDTH-1:0] device,
  input  logic [DEVICE_WIDTH-1:0] next_device,
  output logic                    edge_valid,
  output logic                    edge_last,
  output logic [NODE_BITS-1:0]    src_idx,
  output logic [NODE_BITS-1:0]    dst_idx,
  output logic [NODE_BITS:0]      node_count,
  output logic [NODE_BITS-1:0]    you_idx,
  output logic [NODE_BITS-1:0]    out_idx,
  output logic                    you_found,
  output logic                    out_found,
  output logic                    done,
  output logic                    overflow
);
  localparam logic [NODE_BITS:0] NODE_MAX = {1'b1, {NODE_BITS{1'b0}}};

  state_e                  state_q, state_d;
  logic [DEVICE_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [DEVICE_WIDTH-1:0] dev_q, dev_d, nxt_q, nxt_d;
  logic                    last_q, last_d;
  logic [NODE_BITS-1:0]    src_q, src_d, dst_q, dst_d;
  logic                    src_new_q, src_new_d, dst_new_q, dst_new_d;
  logic [NODE_BITS:0]      node_count_q, node_count_d;
  logic [NODE_BITS-1:0]    you_idx_q, you_idx_d, out_idx_q, out_idx_d;
  logic                    you_found_q, you_found_d, out_found_q, out_found_d;
  logic                    init_done_q, init_done_d, edge_valid_q, edge_valid_d;
  logic                    done_q, done_d, overflow_q, overflow_d;

  logic                    ram_we;
  logic [DEVICE_WIDTH-1:0] ram_addr;
  logic [NODE_BITS:0]      ram_wdata, ram_rdata;

  logic [DEVICE_WIDTH-1:0] cur_name;
  logic [NODE_BITS-1:0]    res_idx;
  logic                    res_new, res_ok;

  name_table_ram #(.ADDR_W(DEVICE_WIDTH), .DATA_W(NODE_BITS + 1)) u_table (
    .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
  );

  // Resolve the name whose table entry is on ram_rdata this cycle. A self-loop
  // reads the destination before the source write lands, so reuse src_q.
  always_comb begin
    cur_name = (state_q == ST_DST) ? nxt_q : dev_q;
    res_idx  = '0;
    res_new  = 1'b0;
    res_ok   = 1'b1;
    if (state_q == ST_DST && nxt_q == dev_q && src_new_q) res_idx = src_q;
    else if (ram_rdata[NODE_BITS])                        res_idx = ram_rdata[NODE_BITS-1:0];
    else if (node_count_q != NODE_MAX) begin
      res_idx = node_count_q[NODE_BITS-1:0];
      res_new = 1'b1;
    end else res_ok = 1'b0;
  end

  // Pending table writes are deferred one state so the single port is free
  // for the next lookup: source entry written in DST, destination in EMIT.
  always_comb begin
    state_d = state_q;           init_cnt_d   = init_cnt_q;
    dev_d = dev_q;               nxt_d = nxt_q;              last_d = last_q;
    src_d = src_q;               dst_d = dst_q;
    src_new_d = src_new_q;       dst_new_d = dst_new_q;
    node_count_d = node_count_q;
    you_idx_d = you_idx_q;       out_idx_d = out_idx_q;
    you_found_d = you_found_q;   out_found_d = out_found_q;
    init_done_d = init_done_q;   edge_valid_d = 1'b0;
    done_d = done_q;             overflow_d = overflow_q;
    ram_we = 1'b0;               ram_addr = device;          ram_wdata = '0;
    case (state_q)
      ST_INIT: begin
        ram_we     = 1'b1;
        ram_addr   = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (connection_valid && !done_q) begin
          dev_d   = device;
          nxt_d   = next_device;
          last_d  = connection_last;
          state_d = ST_SRC;
        end else if (end_of_file) done_d = 1'b1;
      end
      ST_SRC: begin
        ram_addr  = nxt_q;
        src_d     = res_idx;
        src_new_d = res_new;
        state_d   = ST_DST;
      end
      ST_DST: begin
        ram_we       = src_new_q;
        ram_addr     = dev_q;
        ram_wdata    = {1'b1, src_q};
        dst_d        = res_idx;
        dst_new_d    = res_new;
        edge_valid_d = 1'b1;
        state_d      = ST_EMIT;
      end
      ST_EMIT: begin
        ram_we    = dst_new_q;
        ram_addr  = nxt_q;
        ram_wdata = {1'b1, dst_q};
        state_d   = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
    if (state_q == ST_SRC || state_q == ST_DST) begin
      if (res_new) node_count_d = node_count_q + 1'b1;
      if (!res_ok) overflow_d = 1'b1;
      if (res_ok && cur_name == YOU_DEVICE) begin
        you_idx_d   = res_idx;
        you_found_d = 1'b1;
      end
      if (res_ok && cur_name == OUT_DEVICE) begin
        out_idx_d   = res_idx;
        out_found_d = 1'b1;
      end
    end
    if (connection_valid && state_q != ST_IDLE) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;        init_cnt_q <= '0;
      dev_q <= '0;               nxt_q <= '0;             last_q <= 1'b0;
      src_q <= '0;               dst_q <= '0;
      src_new_q <= 1'b0;         dst_new_q <= 1'b0;
      node_count_q <= '0;
      you_idx_q <= '0;           out_idx_q <= '0;
      you_found_q <= 1'b0;       out_found_q <= 1'b0;
      init_done_q <= 1'b0;       edge_valid_q <= 1'b0;
      done_q <= 1'b0;            overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;        init_cnt_q <= init_cnt_d;
      dev_q <= dev_d;            nxt_q <= nxt_d;          last_q <= last_d;
      src_q <= src_d;            dst_q <= dst_d;
      src_new_q <= src_new_d;    dst_new_q <= dst_new_d;
      node_count_q <= node_count_d;
      you_idx_q <= you_idx_d;    out_idx_q <= out_idx_d;
      you_found_q <= you_found_d; out_found_q <= out_found_d;
      init_done_q <= init_done_d; edge_valid_q <= edge_valid_d;
      done_q <= done_d;          overflow_q <= overflow_d;
    end
  end

  assign init_done  = init_done_q;
  assign edge_valid = edge_valid_q;
  assign edge_last  = last_q;
  assign src_idx    = src_q;
  assign dst_idx    = dst_q;
  assign node_count = node_count_q;
  assign you_idx    = you_idx_q;
  assign out_idx    = out_idx_q;
  assign you_found  = you_found_q;
  assign out_found  = out_found_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_device_indexer.sv
// Scoreboard bench for device_indexer: a default-size instance (a) and a
// NODE_BITS=2 instance (b) for the table-full path, sharing clock and reset.
module tb_device_indexer;
  import device_indexer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        cv_a, cl_a, eof_a;
  logic [14:0] dev_a, nxt_a;
  logic        init_a, ev_a, el_a, yf_a, of_a, done_a, ovf_a;
  logic [9:0]  src_a, dst_a, yi_a, oi_a;
  logic [10:0] nc_a;

  logic        cv_b, cl_b, eof_b;
  logic [14:0] dev_b, nxt_b;
  logic        init_b, ev_b, el_b, yf_b, of_b, done_b, ovf_b;
  logic [1:0]  src_b, dst_b, yi_b, oi_b;
  logic [2:0]  nc_b;

  device_indexer dut_a (
    .clk(clk), .rst(rst), .init_done(init_a), .connection_valid(cv_a),
    .connection_last(cl_a), .end_of_file(eof_a), .device(dev_a), .next_device(nxt_a),
    .edge_valid(ev_a), .edge_last(el_a), .src_idx(src_a), .dst_idx(dst_a),
    .node_count(nc_a), .you_idx(yi_a), .out_idx(oi_a), .you_found(yf_a),
    .out_found(of_a), .done(done_a), .overflow(ovf_a)
  );

  device_indexer #(.NODE_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .init_done(init_b), .connection_valid(cv_b),
    .connection_last(cl_b), .end_of_file(eof_b), .device(dev_b), .next_device(nxt_b),
    .edge_valid(ev_b), .edge_last(el_b), .src_idx(src_b), .dst_idx(dst_b),
    .node_count(nc_b), .you_idx(yi_b), .out_idx(oi_b), .you_found(yf_b),
    .out_found(of_b), .done(done_b), .overflow(ovf_b)
  );

  localparam logic [14:0] AAA = 15'h0000, BBB = 15'h0421, CCC = 15'h0842;
  localparam logic [14:0] DDD = 15'h0C63, EEE = 15'h1084;

  typedef struct { bit sel; int src; int dst; bit last; } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;

  // One connection into instance sel; the expected edge goes on the scoreboard
  // at drive time and is popped when that instance strobes edge_valid.
  task automatic run_conn(input bit sel, input logic [14:0] d, input logic [14:0] n,
                          input bit last, input int es, input int ed, input bit set_eof);
    exp_t e;
    bit   seen = 1'b0;
    int   lat, gs, gd;
    bit   gl;
    e.sel = sel; e.src = es; e.dst = ed; e.last = last;
    sb.push_back(e);
    @(negedge clk);
    if (sel) begin cv_b = 1; dev_b = d; nxt_b = n; cl_b = last; end
    else     begin cv_a = 1; dev_a = d; nxt_a = n; cl_a = last; end
    @(negedge clk);
    cv_a = 0; cv_b = 0;
    if (set_eof) eof_a = 1;
    lat = 1;
    while (!seen && lat < 10) begin
      checks++;
      if ((sel ? done_b : done_a) !== 1'b0) begin
        failures++; $display("FAIL early_done: done=1 at cycle %0d, required 0 before edge", lat);
      end
      if (sel ? ev_b : ev_a) seen = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      failures++; $display("FAIL edge_timeout: no edge_valid within %0d cycles", lat);
    end else begin
      gs = sel ? int'(src_b) : int'(src_a);
      gd = sel ? int'(dst_b) : int'(dst_a);
      gl = sel ? el_b : el_a;
      if (lat !== 3) begin failures++; $display("FAIL edge_latency: got %0d required 3", lat); end
      checks++;
      if (gs !== e.src) begin failures++; $display("FAIL src_idx: got %0d required %0d", gs, e.src); end
      checks++;
      if (gd !== e.dst) begin failures++; $display("FAIL dst_idx: got %0d required %0d", gd, e.dst); end
      checks++;
      if (gl !== e.last) begin failures++; $display("FAIL edge_last: got %0d required %0d", gl, e.last); end
      @(negedge clk);
      checks++;
      if ((sel ? ev_b : ev_a) !== 1'b0) begin
        failures++; $display("FAIL edge_pulse: edge_valid still 1 a cycle later, required 0");
      end
    end
  endtask

  task automatic test_reset;
    int n = 0;
    @(negedge clk); rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({init_a, ev_a, nc_a, yf_a, of_a, done_a, ovf_a} !== '0) begin
      failures++; $display("FAIL reset_state: outputs nonzero during rst, required 0");
    end
    rst = 0;
    while (!init_a && n < 40000) begin @(negedge clk); n++; end
    checks++;
    if (n !== 32768) begin failures++; $display("FAIL init_sweep: init_done after %0d cycles required 32768", n); end
    checks++;
    if (init_b !== 1'b1) begin failures++; $display("FAIL init_b: got %0d required 1", init_b); end
    checks++;
    if (nc_a !== 0 || yf_a !== 0 || of_a !== 0) begin
      failures++; $display("FAIL post_init: node_count=%0d you_found=%0d out_found=%0d required 0", nc_a, yf_a, of_a);
    end
  endtask

  task automatic test_basic;
    run_conn(0, AAA, BBB, 0, 0, 1, 0);
    run_conn(0, AAA, CCC, 1, 0, 2, 0);
    checks++;
    if (nc_a !== 3) begin failures++; $display("FAIL basic_count: got %0d required 3", nc_a); end
  endtask

  task automatic test_self_loop;
    run_conn(1, AAA, AAA, 1, 0, 0, 0);
    checks++;
    if (nc_b !== 1) begin failures++; $display("FAIL self_loop_count: got %0d required 1", nc_b); end
  endtask

  task automatic test_overflow;
    run_conn(1, BBB, CCC, 0, 1, 2, 0);
    checks++;
    if (ovf_b !== 0) begin failures++; $display("FAIL ovf_early: got %0d required 0", ovf_b); end
    run_conn(1, DDD, EEE, 1, 3, 0, 0);
    checks++;
    if (ovf_b !== 1) begin failures++; $display("FAIL ovf_set: got %0d required 1", ovf_b); end
    checks++;
    if (nc_b !== 4) begin failures++; $display("FAIL ovf_count: got %0d required 4", nc_b); end
    checks++;
    if ({yf_b, of_b, yi_b, oi_b} !== '0) begin
      failures++; $display("FAIL ovf_special: you/out state %0h required 0", {yf_b, of_b, yi_b, oi_b});
    end
  endtask

  task automatic test_rst_mid;
    int n = 0;
    bit saw_edge = 1'b0;
    @(negedge clk);
    cv_a = 1; dev_a = YOU_DEVICE; nxt_a = OUT_DEVICE; cl_a = 1;
    @(negedge clk); cv_a = 0;
    @(negedge clk); rst = 1;          // instance a is in DST here
    repeat (4) begin
      @(negedge clk);
      if (ev_a) saw_edge = 1'b1;
    end
    checks++;
    if (saw_edge) begin failures++; $display("FAIL rst_mid_edge: edge_valid seen during rst, required none"); end
    checks++;
    if (init_a !== 1'b0) begin failures++; $display("FAIL rst_mid_init: got %0d required 0", init_a); end
    rst = 0;
    while (!init_a && n < 40000) begin
      @(negedge clk); n++;
      if (ev_a) saw_edge = 1'b1;
    end
    checks++;
    if (n !== 32768) begin failures++; $display("FAIL rst_mid_sweep: %0d cycles required 32768", n); end
    checks++;
    if (saw_edge || nc_a !== 0) begin
      failures++; $display("FAIL rst_mid_state: edge=%0d node_count=%0d required 0 0", saw_edge, nc_a);
    end
  endtask

  task automatic test_special;
    run_conn(0, YOU_DEVICE, OUT_DEVICE, 1, 0, 1, 0);
    run_conn(0, BBB, YOU_DEVICE, 1, 2, 0, 0);
    checks++;
    if (yi_a !== 0 || yf_a !== 1) begin failures++; $display("FAIL you: idx=%0d found=%0d required 0 1", yi_a, yf_a); end
    checks++;
    if (oi_a !== 1 || of_a !== 1) begin failures++; $display("FAIL out: idx=%0d found=%0d required 1 1", oi_a, of_a); end
  endtask

  task automatic test_eof;
    int  n = 0;
    bit  saw_edge = 1'b0;
    run_conn(0, CCC, AAA, 1, 3, 4, 1);
    while (!done_a && n < 6) begin @(negedge clk); n++; end
    checks++;
    if (done_a !== 1'b1) begin failures++; $display("FAIL eof_done: got %0d required 1", done_a); end
    checks++;
    if (nc_a !== 5) begin failures++; $display("FAIL eof_count: got %0d required 5", nc_a); end
    @(negedge clk);
    cv_a = 1; dev_a = DDD; nxt_a = EEE; cl_a = 1;
    @(negedge clk); cv_a = 0;
    repeat (6) begin @(negedge clk); if (ev_a) saw_edge = 1'b1; end
    checks++;
    if (saw_edge || done_a !== 1'b1) begin
      failures++; $display("FAIL after_done: edge=%0d done=%0d required 0 1", saw_edge, done_a);
    end
  endtask

  initial begin
    rst = 1; eof_a = 0; eof_b = 0;
    cv_a = 0; cl_a = 0; dev_a = '0; nxt_a = '0;
    cv_b = 0; cl_b = 0; dev_b = '0; nxt_b = '0;
    test_reset;
    test_basic;
    test_self_loop;
    test_overflow;
    test_rst_mid;
    test_special;
    test_eof;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
